// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard unit.
package fwd_pkg;

    localparam int RA_W_DEF = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    typedef struct packed {
        logic [RA_W_DEF-1:0] rd;
        logic                regwr;
        logic                memrd;
    } stage_t;

    typedef struct packed {
        logic [RA_W_DEF-1:0] rd;
        logic                regwr;
    } wr_t;

    // A writer only counts if it really writes and does not target the hard-wired zero register.
    function automatic logic writer_hits(logic [RA_W_DEF-1:0] rd, logic regwr,
                                         logic [RA_W_DEF-1:0] src);
        return regwr && (rd != '0) && (rd == src);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / forwarding-select bundle for fwd_hazard_unit.
// HAZARD_STATS_EN adds the stall_cnt / fwd_cnt statistics outputs.
interface fwd_hazard_unit_if import fwd_pkg::*; #(parameter int RA_W = RA_W_DEF);

    logic            id_valid;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic [RA_W-1:0] id_rd;
    logic            id_regwr;
    logic            id_memrd;
    logic            flush;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            stall;
`ifdef HAZARD_STATS_EN
    logic [31:0]     stall_cnt;
    logic [31:0]     fwd_cnt;
`endif

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_regwr, id_memrd, flush,
        input  fwd_a, fwd_b, stall
`ifdef HAZARD_STATS_EN
        , input stall_cnt, fwd_cnt
`endif
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_regwr, id_memrd, flush,
        output fwd_a, fwd_b, stall
`ifdef HAZARD_STATS_EN
        , output stall_cnt, fwd_cnt
`endif
    );

endinterface

// File: rtl/fwd_hazard_unit_sel.sv
// One operand's forwarding select: EX/MEM writer beats MEM/WB writer beats the register file.
module fwd_sel import fwd_pkg::*; (
    input  logic [RA_W_DEF-1:0] src,
    input  wr_t                 mem,
    input  wr_t                 wb,
    output logic [1:0]          sel
);

    always_comb begin
        sel = FWD_REGFILE;
        if (writer_hits(mem.rd, mem.regwr, src)) begin
            sel = FWD_EXMEM;
        end else if (writer_hits(wb.rd, wb.regwr, src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select generator and load-use stall detector with private EX/MEM/WB shadow registers.
// HAZARD_STATS_EN adds free-running stall and forward-cycle counters.
module fwd_hazard_unit import fwd_pkg::*; #(
    parameter int RA_W = RA_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    fwd_hazard_unit_if.slave   bus
);

    stage_t          ex_q;
    logic [RA_W-1:0] ex_rs;
    logic [RA_W-1:0] ex_rt;
    wr_t             mem_q;
    wr_t             wb_q;
    logic            bubble;

    // A stalled, flushed or empty ID slot enters EX with its enables cleared; fields are kept.
    assign bubble = bus.stall | bus.flush | ~bus.id_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q  <= '0;
            ex_rs <= '0;
            ex_rt <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_rs       <= bus.id_rs;
            ex_rt       <= bus.id_rt;
            ex_q.rd     <= bus.id_rd;
            ex_q.regwr  <= bus.id_regwr & ~bubble;
            ex_q.memrd  <= bus.id_memrd & ~bubble;
            mem_q.rd    <= ex_q.rd;
            mem_q.regwr <= ex_q.regwr;
            wb_q        <= mem_q;
        end
    end

    fwd_sel u_sel_a (
        .src (ex_rs),
        .mem (mem_q),
        .wb  (wb_q),
        .sel (bus.fwd_a)
    );

    fwd_sel u_sel_b (
        .src (ex_rt),
        .mem (mem_q),
        .wb  (wb_q),
        .sel (bus.fwd_b)
    );

    // Load in EX whose result is needed by ID cannot be forwarded in time.
    assign bus.stall = bus.id_valid &
                       (writer_hits(ex_q.rd, ex_q.memrd, bus.id_rs) |
                        writer_hits(ex_q.rd, ex_q.memrd, bus.id_rt));

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (bus.stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((bus.fwd_a != FWD_REGFILE) || (bus.fwd_b != FWD_REGFILE)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: drives ID-stage instructions and checks forward selects and stall.
module tb_fwd_hazard_unit;

    logic clock;
    logic reset;
    int   tests;
    int   failed;

    fwd_hazard_unit_if bus ();

    fwd_hazard_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic regwr, input logic memrd,
                                 input logic fl);
        bus.id_valid = valid;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        bus.id_rd    = rd;
        bus.id_regwr = regwr;
        bus.id_memrd = memrd;
        bus.flush    = fl;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic regwr, input logic memrd);
        applyStimulus(1'b1, rs, rt, rd, regwr, memrd, 1'b0);
        tick();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                               input logic es);
        tests++;
        assert (bus.fwd_a === ea) else begin
            failed++;
            $error("[TB] FAIL %s fwd_a observed=%b expected=%b", tag, bus.fwd_a, ea);
        end
        tests++;
        assert (bus.fwd_b === eb) else begin
            failed++;
            $error("[TB] FAIL %s fwd_b observed=%b expected=%b", tag, bus.fwd_b, eb);
        end
        tests++;
        assert (bus.stall === es) else begin
            failed++;
            $error("[TB] FAIL %s stall observed=%b expected=%b", tag, bus.stall, es);
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic checkCount(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask
`endif

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset", 2'b00, 2'b00, 1'b0);
        reset = 1'b0;

        // EX/MEM forward: add $3 then a consumer of $3 in rs
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        checkOutput("first_add", 2'b00, 2'b00, 1'b0);
        issue(5'd3, 5'd4, 5'd6, 1'b1, 1'b0);
        checkOutput("exmem_a", 2'b10, 2'b00, 1'b0);
        nops(3);

        // MEM/WB forward: add $3; nop; sub rt=$3
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        nops(1);
        issue(5'd4, 5'd3, 5'd8, 1'b1, 1'b0);
        checkOutput("memwb_b", 2'b00, 2'b01, 1'b0);
        nops(3);

        // Both stages write $3: the younger (EX/MEM) wins
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        issue(5'd3, 5'd9, 5'd10, 1'b1, 1'b0);
        checkOutput("priority", 2'b10, 2'b00, 1'b0);
        nops(3);

        // Load-use: lw $5; add $7 <- $5 + $7
        issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        checkOutput("lw_in_ex", 2'b00, 2'b00, 1'b0);
        applyStimulus(1'b1, 5'd5, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("loaduse_stall", 2'b00, 2'b00, 1'b1);
        tick();
        checkOutput("bubble_cycle", 2'b10, 2'b00, 1'b0);
        tick();
        checkOutput("after_stall", 2'b01, 2'b00, 1'b0);
        nops(3);

        // Register 0 is never forwarded and never stalls
        issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        checkOutput("zero_fwd", 2'b00, 2'b00, 1'b0);
        nops(3);
        issue(5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("zero_stall", 2'b00, 2'b00, 1'b0);
        tick();
        checkOutput("zero_after", 2'b00, 2'b00, 1'b0);
        nops(3);

        // Flushed load must neither stall nor forward
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("flush_nostall", 2'b00, 2'b00, 1'b0);
        tick();
        checkOutput("flush_nofwd", 2'b00, 2'b00, 1'b0);
        nops(3);

        // Back-to-back loads to $5, then a single use
        issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        issue(5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("b2b_stall", 2'b00, 2'b00, 1'b1);
        tick();
        checkOutput("b2b_single", 2'b10, 2'b00, 1'b0);
        tick();
        checkOutput("b2b_fwd", 2'b01, 2'b00, 1'b0);
        nops(3);

        // Reset while a stall is pending
        issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("pre_reset_stall", 2'b00, 2'b00, 1'b1);
        reset = 1'b1;
        tick();
        checkOutput("reset_mid_stall", 2'b00, 2'b00, 1'b0);
`ifdef HAZARD_STATS_EN
        checkCount("stall_cnt_reset", bus.stall_cnt, 32'd0);
        checkCount("fwd_cnt_reset", bus.fwd_cnt, 32'd0);
`endif
        reset = 1'b0;
        tick();
        checkOutput("post_reset", 2'b00, 2'b00, 1'b0);
        issue(5'd6, 5'd0, 5'd9, 1'b1, 1'b0);
        checkOutput("no_residual_bubble", 2'b10, 2'b00, 1'b0);
        nops(3);

`ifdef HAZARD_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
            applyStimulus(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
            nops(3);
        end
        checkCount("stall_cnt_three", bus.stall_cnt, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
